seq_mult4_ctrl: RTL and testbench
=================================

// Module: seq_mult4_ctrl
// PURPOSE
//  Sequential shift-and-add unsigned multiplier controller. It is the stage
//  directly around the 4-bit ripple-carry adder. Each cycle it drives the
//  adder's operand and carry-in inputs, then consumes the adder's sum and
//  carry-out and shifts them into its accumulator.
//  WIDTH x WIDTH unsigned product in WIDTH iterations; start/busy/done handshake.
// PARAMETERS
//  WIDTH   4   operand width; must equal the width of the attached adder
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  start      in   1        request; sampled only in IDLE
//  mcand      in   WIDTH    multiplicand; captured with start
//  mplier     in   WIDTH    multiplier; captured with start
//  busy       out  1        high while in RUN or DONE
//  done       out  1        one-cycle pulse; product valid from this cycle
//  product    out  2*WIDTH  registered result; held until next DONE
//  add_a      out  WIDTH    adder operand A = accumulator A_reg
//  add_b      out  WIDTH    adder operand B = Q_reg[0] ? M_reg : 0
//  add_cin    out  1        adder carry-in; constant 0
//  add_s      in   WIDTH    adder sum (combinational return)
//  add_cout   in   1        adder carry-out (combinational return)
// BEHAVIOUR
//  - Registers: M_reg, Q_reg, A_reg (WIDTH each), cnt (log2 WIDTH bits),
//    state, product.
//  - Reset values: state=IDLE; A_reg, Q_reg, M_reg and cnt = 0;
//    busy=0, done=0, product=0, add_a=0, add_b=0.
//  - IDLE: busy=0.
//    If start=1: M_reg<=mcand, Q_reg<=mplier, A_reg<=0, cnt<=0, go to RUN.
//  - RUN, one iteration per cycle:
//    A_reg <= {add_cout, add_s[WIDTH-1:1]};
//    Q_reg <= {add_s[0], Q_reg[WIDTH-1:1]};
//    cnt <= cnt+1.
//    When cnt==WIDTH-1: product <= {next A_reg, next Q_reg}; go to DONE.
//  - DONE: done=1 for exactly this cycle; go to IDLE next cycle.
//  - Latency: start high in cycle 0 gives RUN in cycles 1..WIDTH and
//    done=1 in cycle WIDTH+1.
//    The earliest next start is accepted in cycle WIDTH+2.
//  - start while busy (RUN or DONE): ignored; no queueing.
//  - The adder's carry-out is never lost: it becomes A_reg MSB after each shift.
//    The product fits in 2*WIDTH bits; no overflow is possible.
//  - add_cin is tied to 0 in all states.
//    In IDLE and DONE, add_b=0 (adder outputs unused).
//  - rst asserted mid-RUN: next cycle is IDLE with reset values. No done pulse.
//    product is cleared to 0.
//  - rst and start in the same cycle: rst wins; the operation is not accepted.
//  - Operand ports are don't-care except in the start cycle in IDLE.
// TESTING
//  (bench instantiates the 4-bit ripple-carry adder on the add_* ports)
//  1. start, mcand=4'hF, mplier=4'hF -> done in cycle 5, product=8'hE1 (225);
//     add_cout=1 seen in RUN.
//  2. mcand=4'hD, mplier=4'hB -> product=8'h8F (143);
//     add_b=0 in cycles where Q_reg[0]=0.
//  3. mcand=0 or mplier=0 -> product=8'h00.
//     busy high in cycles 1-5; done for one cycle only.
//  4. start held high continuously with changing operands:
//     ops accepted every 6 cycles; mid-op operand changes do not affect the result.
//  5. rst pulse in cycle 3 of RUN -> IDLE, product=0, no done.
//     A following 7x9 returns 8'h3F (63).
//  6. Exhaustive 256 operand pairs, back-to-back:
//     every product equals mcand*mplier; add_cin always 0.

Source files
------------

// File: rtl/seq_mult4_ctrl.sv
// rtl/seq_mult4_ctrl.sv - shift-and-add unsigned multiplier controller around an external adder
// Drives the adder operands each RUN cycle and shifts {cout, sum} back into A:Q.
module seq_mult4_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = mcand;
                    q_d     = mplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The carry-out becomes the new A MSB, so no product bit is lost.
                a_d   = {add_cout, add_s[WIDTH-1:1]};
                q_d   = {add_s[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    product_d = {a_d, q_d};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;
    assign add_a   = a_q;
    assign add_b   = ((state_q == ST_RUN) && q_q[0]) ? m_q : '0;
    assign add_cin = 1'b0;

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// tb/tb_seq_mult4_ctrl.sv - randomized self-checking bench for seq_mult4_ctrl
module tb_seq_mult4_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_s;
    logic           add_cout;

    always #5 clk = ~clk;

    // 4-bit ripple-carry adder seen by the controller
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    seq_mult4_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1..W run (phase-1 iterations done), W+1 done
    int model_ready = 0;
    int phase   = 0;
    int op_m    = 0;
    int op_q    = 0;
    int exp_prod = 0;
    int a_hold  = 0;
    int accepts = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            phase = 0; exp_prod = 0; a_hold = 0; model_ready = 1;
        end else if (phase == 0) begin
            if (start) begin
                op_m = int'(mcand); op_q = int'(mplier); phase = 1; accepts++;
            end
        end else if (phase <= W) begin
            phase++;
            if (phase == W + 1) begin
                exp_prod = op_m * op_q;
                a_hold   = (op_m * op_q) >> W;
            end
        end else begin
            phase = 0;
        end
    endtask

    task automatic compare_all();
        int ea, eb, it;
        if (model_ready == 0) return;
        if (phase >= 1 && phase <= W) begin
            it = phase - 1;
            ea = (op_m * (op_q & ((1 << it) - 1))) >> it;
            eb = ((op_q >> it) & 1) != 0 ? op_m : 0;
        end else begin
            ea = a_hold;
            eb = 0;
        end
        chk("busy", int'(busy), (phase != 0) ? 1 : 0);
        chk("done", int'(done), (phase == W + 1) ? 1 : 0);
        chk("product", int'(product), exp_prod);
        chk("add_a", int'(add_a), ea);
        chk("add_b", int'(add_b), eb);
        chk("add_cin", int'(add_cin), 0);
    endtask

    // One clock: DUT and model advance at posedge, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Issue one op from idle; returns product at done, latency and whether cout=1 was seen in RUN.
    task automatic do_op(input int m, input int q, output int p, output int lat, output int cout_seen);
        start  = 1'b1;
        mcand  = W'(m);
        mplier = W'(q);
        tick();
        start     = 1'b0;
        lat       = 1;
        cout_seen = 0;
        while (!done && lat < 20) begin
            if (busy && add_cout) cout_seen = 1;
            mcand  = W'($urandom);
            mplier = W'($urandom);
            tick();
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
        p = int'(product);
        tick();
    endtask

    initial begin
        int p, lat, cs, acc0, dones;
        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product", int'(product), 0);
        chk("rst_add_a", int'(add_a), 0);
        chk("rst_add_b", int'(add_b), 0);
        rst = 1'b0;
        tick();

        do_op(15, 15, p, lat, cs);
        chk("t1_product", p, 'hE1);
        chk("t1_latency", lat, 5);
        chk("t1_cout_seen", cs, 1);

        do_op(13, 11, p, lat, cs);
        chk("t2_product", p, 'h8F);

        do_op(0, 9, p, lat, cs);
        chk("t3a_product", p, 0);
        do_op(6, 0, p, lat, cs);
        chk("t3b_product", p, 0);

        acc0 = accepts;
        for (int k = 0; k < 24; k++) begin
            start  = 1'b1;
            mcand  = W'($urandom);
            mplier = W'($urandom);
            tick();
        end
        start = 1'b0;
        chk("t4_accepts", accepts - acc0, 4);
        for (int k = 0; k < 8; k++) tick();

        start = 1'b1; mcand = W'(10); mplier = W'(5);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy_after_rst", int'(busy), 0);
        chk("t5_product_after_rst", int'(product), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) dones++;
        end
        chk("t5_no_done", dones, 0);
        do_op(7, 9, p, lat, cs);
        chk("t5_7x9", p, 'h3F);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; mcand = W'(3); mplier = W'(3);
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        tick();

        for (int k = 0; k < 40; k++) begin
            int rm, rq;
            rm = int'($urandom_range(15, 0));
            rq = int'($urandom_range(15, 0));
            do_op(rm, rq, p, lat, cs);
            chk("rand_product", p, rm * rq);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(i, j, p, lat, cs);
                chk("exh_product", p, i * j);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
